// File: rtl/tdm_demux1to4.sv
// ---------------------------------------------------------------------------
// tdm_demux1to4
//   Receive end of a 4-slot TDM link. Slot words arrive one per enable
//   strobe, with a frame-sync flag marking slot 0. A slot counter tracks the
//   position within the frame, and shadow registers collect slots 0..2. On
//   slot 3 the whole frame is presented on y as four parallel channel words.
//   The block also keeps a good-frame counter that drives a lock flag, and it
//   flags alignment errors (missing or early sync).
//
// Parameters
//   W           width of one slot word
//   LOCK_FRAMES consecutive good frames before lock asserts (1..15)
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   en    in   slot strobe; d and fs are sampled only when en=1
//   d     in   slot data word [W-1:0]
//   fs    in   frame sync, high with the slot-0 word
//   y     out  last complete frame, slot 0 in the LSBs [4*W-1:0]
//   s     out  index of the next slot expected
//   vld   out  one-cycle pulse, y holds a new frame
//   lock  out  frame alignment stable
//   err   out  one-cycle pulse, alignment error detected
// ---------------------------------------------------------------------------
module tdm_demux1to4 #(
   parameter int W           = 1,
   parameter int LOCK_FRAMES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [W-1:0]   d,
   input  logic           fs,
   output logic [4*W-1:0] y,
   output logic [1:0]     s,
   output logic           vld,
   output logic           lock,
   output logic           err
);

   localparam logic [0:0] ST_HUNT  = 1'b0;
   localparam logic [0:0] ST_SYNC  = 1'b1;
   localparam logic [3:0] GOOD_MAX = 4'(LOCK_FRAMES);

   logic [0:0]     state_q, state_d;
   logic [1:0]     s_q, s_d;
   logic [W-1:0]   sh0_q, sh0_d;
   logic [W-1:0]   sh1_q, sh1_d;
   logic [W-1:0]   sh2_q, sh2_d;
   logic [4*W-1:0] y_q, y_d;
   logic [3:0]     good_q, good_d;
   logic           vld_q, vld_d;
   logic           err_q, err_d;
   logic           lock_q, lock_d;
   logic [3:0]     good_inc;

   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one unassigned (no latches).
      state_d  = state_q;
      s_d      = s_q;
      sh0_d    = sh0_q;
      sh1_d    = sh1_q;
      sh2_d    = sh2_q;
      y_d      = y_q;
      good_d   = good_q;
      lock_d   = lock_q;
      vld_d    = 1'b0;
      err_d    = 1'b0;
      good_inc = (good_q == GOOD_MAX) ? good_q : good_q + 4'd1;

      if (en) begin
         if (state_q == ST_HUNT) begin
            // While hunting, only a sync word is accepted. It starts a frame.
            if (fs) begin
               sh0_d   = d;
               s_d     = 2'd1;
               state_d = ST_SYNC;
            end
         end else if (fs) begin
            // A sync word anywhere other than slot 0 aborts the partial frame.
            // It is still a valid slot 0, so a new frame starts right away.
            if (s_q != 2'd0) begin
               err_d  = 1'b1;
               good_d = 4'd0;
               lock_d = 1'b0;
            end
            sh0_d = d;
            s_d   = 2'd1;
         end else if (s_q == 2'd0) begin
            // Slot 0 arrived without sync: alignment lost, so hunt again.
            err_d   = 1'b1;
            good_d  = 4'd0;
            lock_d  = 1'b0;
            state_d = ST_HUNT;
         end else begin
            case (s_q)
               2'd1: begin
                  sh1_d = d;
                  s_d   = 2'd2;
               end
               2'd2: begin
                  sh2_d = d;
                  s_d   = 2'd3;
               end
               default: begin
                  y_d    = {d, sh2_q, sh1_q, sh0_q};
                  vld_d  = 1'b1;
                  s_d    = 2'd0;
                  good_d = good_inc;
                  if (good_inc == GOOD_MAX) lock_d = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
      if (rst) begin
         state_q <= ST_HUNT;
         s_q     <= 2'd0;
         sh0_q   <= '0;
         sh1_q   <= '0;
         sh2_q   <= '0;
         y_q     <= '0;
         good_q  <= 4'd0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         y_q     <= y_d;
         good_q  <= good_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         lock_q  <= lock_d;
      end
   end

   assign y    = y_q;
   assign s    = s_q;
   assign vld  = vld_q;
   assign lock = lock_q;
   assign err  = err_q;

endmodule

// File: tb/tb_tdm_demux1to4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux1to4
//   Self-checking bench for tdm_demux1to4 with W=4 and LOCK_FRAMES=2.
//   Part 1 applies a table of directed vectors with fixed expected outputs.
//   Part 2 is a gapped-enable sequence.
//   Part 3 drives random strobes and compares against a frame-level model.
// ---------------------------------------------------------------------------
module tb_tdm_demux1to4;

   localparam int W  = 4;
   localparam int LF = 2;

   logic           clk = 1'b0;
   logic           rst, en, fs;
   logic [W-1:0]   d;
   logic [4*W-1:0] y;
   logic [1:0]     s;
   logic           vld, lock, err;

   int n_checks = 0;
   int n_errors = 0;

   tdm_demux1to4 #(.W(W), .LOCK_FRAMES(LF)) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d),
      .fs  (fs),
      .y   (y),
      .s   (s),
      .vld (vld),
      .lock(lock),
      .err (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, en, fs;
      logic [3:0]  d;
      logic [15:0] y;
      logic [1:0]  s;
      logic        vld, lock, err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, e, f, input logic [3:0] dd,
                      input logic [15:0] ey, input logic [1:0] es,
                      input logic ev, el, ee);
      vec_t v;
      v.rst = r; v.en = e; v.fs = f; v.d = dd;
      v.y = ey; v.s = es; v.vld = ev; v.lock = el; v.err = ee;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs. The sample point is 1 time unit after the edge.
   task automatic drive(input logic r, e, f, input logic [3:0] dd);
      rst = r; en = e; fs = f; d = dd;
      @(posedge clk);
      #1;
   endtask

   // ---------------- frame-level reference model ----------------
   bit         m_hunt;
   int         m_slot;
   logic [3:0] m_words[4];
   logic [15:0] m_y;
   int         m_good;
   bit         m_lock, m_vld, m_err;

   function automatic void model_reset();
      m_hunt = 1; m_slot = 0; m_y = '0; m_good = 0;
      m_lock = 0; m_vld = 0; m_err = 0;
      for (int i = 0; i < 4; i++) m_words[i] = '0;
   endfunction

   function automatic void lose_align();
      m_err = 1; m_good = 0; m_lock = 0;
   endfunction

   function automatic void model_step(input logic r, e, f, input logic [3:0] dd);
      m_vld = 0; m_err = 0;
      if (r) begin
         model_reset();
      end else if (e) begin
         if (m_hunt) begin
            if (f) begin m_words[0] = dd; m_slot = 1; m_hunt = 0; end
         end else if (f) begin
            if (m_slot != 0) lose_align();
            m_words[0] = dd; m_slot = 1;
         end else if (m_slot == 0) begin
            lose_align(); m_hunt = 1;
         end else begin
            m_words[m_slot] = dd;
            m_slot = (m_slot + 1) % 4;
            if (m_slot == 0) begin
               m_y = {m_words[3], m_words[2], m_words[1], m_words[0]};
               m_vld = 1;
               if (m_good < LF) m_good = m_good + 1;
               if (m_good == LF) m_lock = 1;
            end
         end
      end
   endfunction

   initial begin
      logic [3:0] gw[4];
      logic [15:0] y_hold;
      int vld_count;
      logic r, e, f;
      logic [3:0] dd;

      // ------------- directed vector table -------------
      //     rst en fs d      y        s  vld lock err
      add(1, 0, 0, 4'h0, 16'h0000, 0, 0, 0, 0);   // reset
      add(0, 1, 0, 4'h5, 16'h0000, 0, 0, 0, 0);   // HUNT discard
      add(0, 1, 0, 4'h6, 16'h0000, 0, 0, 0, 0);
      add(0, 1, 1, 4'h1, 16'h0000, 1, 0, 0, 0);
      add(0, 1, 0, 4'h2, 16'h0000, 2, 0, 0, 0);
      add(0, 1, 0, 4'h3, 16'h0000, 3, 0, 0, 0);
      add(0, 1, 0, 4'h4, 16'h4321, 0, 1, 0, 0);   // first good frame
      add(0, 1, 1, 4'hA, 16'h4321, 1, 0, 0, 0);
      add(0, 1, 0, 4'hB, 16'h4321, 2, 0, 0, 0);
      add(0, 1, 0, 4'hC, 16'h4321, 3, 0, 0, 0);
      add(0, 1, 0, 4'hD, 16'hDCBA, 0, 1, 1, 0);   // second frame -> lock
      add(0, 0, 1, 4'hF, 16'hDCBA, 0, 0, 1, 0);   // idle holds
      add(0, 1, 0, 4'h5, 16'hDCBA, 0, 0, 0, 1);   // missing sync
      add(0, 1, 0, 4'h3, 16'hDCBA, 0, 0, 0, 0);   // now hunting: no err
      add(0, 1, 1, 4'h1, 16'hDCBA, 1, 0, 0, 0);
      add(0, 1, 0, 4'h2, 16'hDCBA, 2, 0, 0, 0);
      add(0, 1, 0, 4'h3, 16'hDCBA, 3, 0, 0, 0);
      add(0, 1, 0, 4'h4, 16'h4321, 0, 1, 0, 0);   // vld but no lock yet
      add(0, 1, 1, 4'h1, 16'h4321, 1, 0, 0, 0);
      add(0, 1, 0, 4'h2, 16'h4321, 2, 0, 0, 0);
      add(0, 1, 1, 4'h9, 16'h4321, 1, 0, 0, 1);   // early sync at s=2
      add(0, 1, 0, 4'h8, 16'h4321, 2, 0, 0, 0);
      add(0, 1, 0, 4'h7, 16'h4321, 3, 0, 0, 0);
      add(0, 1, 0, 4'h6, 16'h6789, 0, 1, 0, 0);
      add(0, 1, 1, 4'hA, 16'h6789, 1, 0, 0, 0);
      add(0, 1, 0, 4'hB, 16'h6789, 2, 0, 0, 0);
      add(1, 1, 0, 4'hC, 16'h0000, 0, 0, 0, 0);   // reset mid-frame wins
      add(0, 1, 1, 4'h1, 16'h0000, 1, 0, 0, 0);
      add(0, 1, 0, 4'h2, 16'h0000, 2, 0, 0, 0);
      add(0, 1, 0, 4'h3, 16'h0000, 3, 0, 0, 0);
      add(0, 1, 0, 4'h4, 16'h4321, 0, 1, 0, 0);
      add(0, 1, 1, 4'h5, 16'h4321, 1, 0, 0, 0);   // back-to-back frame
      add(0, 1, 0, 4'h6, 16'h4321, 2, 0, 0, 0);
      add(0, 1, 0, 4'h7, 16'h4321, 3, 0, 0, 0);
      add(0, 1, 0, 4'h8, 16'h8765, 0, 1, 1, 0);
      add(0, 1, 1, 4'h0, 16'h8765, 1, 0, 1, 0);   // third frame, lock holds
      add(0, 1, 0, 4'h0, 16'h8765, 2, 0, 1, 0);
      add(0, 1, 0, 4'h0, 16'h8765, 3, 0, 1, 0);
      add(0, 1, 0, 4'hF, 16'hF000, 0, 1, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].fs, vecs[i].d);
         check($sformatf("vec%0d.y", i),    32'(y),    32'(vecs[i].y));
         check($sformatf("vec%0d.s", i),    32'(s),    32'(vecs[i].s));
         check($sformatf("vec%0d.vld", i),  32'(vld),  32'(vecs[i].vld));
         check($sformatf("vec%0d.lock", i), 32'(lock), 32'(vecs[i].lock));
         check($sformatf("vec%0d.err", i),  32'(err),  32'(vecs[i].err));
      end

      // ------------- gapped enable: 3 idle cycles between strobes -------------
      drive(1, 0, 0, 4'h0);
      gw = '{4'hA, 4'hB, 4'hC, 4'hD};
      vld_count = 0;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, (i == 0), gw[i]);
         if (vld) vld_count++;
         check($sformatf("gap.s%0d", i), 32'(s), 32'((i + 1) % 4));
         check($sformatf("gap.err%0d", i), 32'(err), 32'(0));
         y_hold = y;
         for (int g = 0; g < 3; g++) begin
            drive(0, 0, 1'($urandom), 4'($urandom));
            if (vld) vld_count++;
            check($sformatf("gap.hold_s%0d_%0d", i, g), 32'(s), 32'((i + 1) % 4));
            check($sformatf("gap.hold_y%0d_%0d", i, g), 32'(y), 32'(y_hold));
         end
      end
      check("gap.y", 32'(y), 32'h0000_DCBA);
      check("gap.vld_count", 32'(vld_count), 32'(1));

      // ------------- randomized run against the model -------------
      drive(1, 0, 0, 4'h0);
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(0, 299) == 0);
         e  = ($urandom_range(0, 3) != 0);
         if (m_hunt || m_slot == 0) f = ($urandom_range(0, 7) != 0);
         else                       f = ($urandom_range(0, 19) == 0);
         dd = 4'($urandom);
         drive(r, e, f, dd);
         model_step(r, e, f, dd);
         check($sformatf("rnd%0d.y", n),    32'(y),    32'(m_y));
         check($sformatf("rnd%0d.s", n),    32'(s),    32'(m_slot));
         check($sformatf("rnd%0d.vld", n),  32'(vld),  32'(m_vld));
         check($sformatf("rnd%0d.lock", n), 32'(lock), 32'(m_lock));
         check($sformatf("rnd%0d.err", n),  32'(err),  32'(m_err));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tdm_demux1to4.md
# tdm_demux1to4

Registered 1-to-4 time-division demultiplexer: the receive end of a 4-slot TDM link whose transmit side is a 4:1 mux that steps its select through slots 0..3.
- Accepts one slot word per enable strobe plus a frame-sync flag marking slot 0.
- Tracks slot position with a counter and reassembles each frame into four parallel channel words.
- Reports frame-complete, lock and alignment-error status to downstream logic.

## Interface
Parameters:
- W, 1, width of one slot word (bits)
- LOCK_FRAMES, 2, consecutive good frames required before `lock` asserts (1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  slot strobe; `d` and `fs` are sampled only on cycles with en=1
- d  input  W  slot data word
- fs  input  1  frame sync; high together with the slot-0 word
- y  output  4*W  last complete frame; y[W-1:0]=slot 0 … y[4W-1:3W]=slot 3
- s  output  2  index of the next slot expected (slot counter)
- vld  output  1  one-cycle pulse: `y` was updated with a new frame
- lock  output  1  frame alignment stable
- err  output  1  one-cycle pulse: alignment error detected

## Operation
- State machine with two states, HUNT and SYNC. The reset state is HUNT.
- Internal shadow registers sh0..sh2 (W bits each) hold partial frames. Frame counter `good` is 0..LOCK_FRAMES, saturating.
- Cycles with en=0: all state, `s`, `y`, `lock` and shadow registers hold. `vld`=0, `err`=0.
- HUNT, en=1:
  - fs=1: sh0<=d, s<=1, go to SYNC.
  - fs=0: the word is discarded; nothing changes.
- SYNC, en=1, s=0:
  - fs=1: sh0<=d, s<=1.
  - fs=0: missing sync. err<=1, good<=0, lock<=0, s<=0, go to HUNT.
- SYNC, en=1, s≠0, fs=1: early sync.
  - err<=1, good<=0, lock<=0.
  - The partial frame is dropped and the word is taken as a new slot 0: sh0<=d, s<=1.
  - State stays SYNC.
- SYNC, en=1, s=1 or 2, fs=0: sh[s]<=d, s<=s+1.
- SYNC, en=1, s=3, fs=0:
  - y<={d, sh2, sh1, sh0}, vld<=1, s<=0 (wrap-around).
  - good<=min(good+1, LOCK_FRAMES).
  - lock<=1 when the incremented good equals LOCK_FRAMES.
- `vld` pulses for every completed frame, whether or not `lock` is set.
- `y` changes only on vld cycles.
- Precedence within one cycle: rst > fs alignment checks > data capture.

## Timing
- Reset values: y=0, s=0, vld=0, lock=0, err=0, sh0..sh2=0, good=0, state=HUNT.
- Latency: `y` and `vld` update on the clock edge that samples slot 3. They are visible the cycle after the slot-3 strobe.
- `err` is visible the cycle after the offending strobe and lasts exactly one cycle.
- `lock` rises in the same cycle as the vld of the LOCK_FRAMES-th consecutive good frame. It falls in the same cycle as err.
- Back-to-back strobes (en=1 every cycle) are supported. The maximum frame rate is one frame per 4 clocks.
- Gaps in `en` of any length between slots are legal and do not affect alignment.
- rst mid-frame: the partial frame is discarded and all outputs return to reset values on the next edge. `y` is cleared.

## Test plan
- Reset, W=4, LOCK_FRAMES=2:
  - Strobes (fs,d) = (1,A),(0,B),(0,C),(0,D).
  - Required: y=16'hDCBA and vld=1 one cycle after the 4th strobe. err=0, lock=0.
  - A second identical frame gives vld=1 and lock=1.
- Gapped enable: the same frame with en low for 3 cycles between each strobe.
  - Required: y=16'hDCBA; vld pulses exactly once.
  - s sequence: 1,2,3,0. All values hold during gaps.
- HUNT discard: after reset, send (0,5),(0,6), then a valid frame 1,2,3,4.
  - Required: the first two words are ignored, y=16'h4321, single vld.
- Missing sync: after lock is set, send a slot-0 strobe with fs=0.
  - Required: err=1 for one cycle, lock=0, s=0, state HUNT, y unchanged.
  - A following valid frame gives vld but lock stays 0 until LOCK_FRAMES good frames.
- Early sync: with s=2, strobe (1,9), then (0,8),(0,7),(0,6).
  - Required: err pulse, no vld for the aborted frame, then y=16'h6789 with vld.
- Reset mid-frame: assert rst after 2 of 4 strobes.
  - Required: y=0, s=0, lock=0, vld=0, err=0 next cycle.
  - A following full frame decodes correctly.
